// File: rtl/bbox_pkg.sv
// rtl/bbox_pkg.sv - shared types and field positions for the bounding-box image loader
package bbox_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      KICK,
      RELEASE,
      WAIT,
      CAPTURE
   } loader_state_t;

   localparam int BBRESET_DEFAULT = 99999;

   localparam int DATA_MSB = 31;
   localparam int DATA_LSB = 24;
   localparam int IDX_MSB  = 23;

   localparam int XMIN_LSB = 24;
   localparam int XMAX_LSB = 16;
   localparam int YMIN_LSB = 8;
   localparam int YMAX_LSB = 0;

endpackage

// File: rtl/bbox_wait_timer.sv
// rtl/bbox_wait_timer.sv - loadable down-counter; done is high while enabled at zero
module bbox_wait_timer #(
   parameter int WIDTH = 16
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (en && count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign done = en && (count == '0);

endmodule

// File: rtl/bbox_image_loader.sv
// rtl/bbox_image_loader.sv - pixel stream to engine RAM writes, restart, timed coordinate capture
// Optional running pixel checksum enabled by defining BBOX_CHECKSUM_EN.
module bbox_image_loader
   import bbox_pkg::*;
#(
   parameter int IMG_W       = 100,
   parameter int IMG_H       = 100,
   parameter int BBRESET     = BBRESET_DEFAULT,
   parameter int RESULT_WAIT = 65536
) (
   input  logic        CLOCK_50,
   input  logic        reset_n,
   input  logic        frame_start,
   input  logic        pix_valid,
   input  logic [7:0]  pix_data,
   input  logic        pix_last,
   output logic        pix_ready,
   output logic        wr_en,
   output logic        rd_en,
   output logic [31:0] hex_value_index,
   input  logic [31:0] coordinates,
   output logic [31:0] result,
   output logic        result_valid,
   output logic        busy,
   output logic        frame_err,
   output logic [15:0] checksum
);

   localparam int NUM_PIXELS = IMG_W * IMG_H;
   localparam int IDX_W      = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
   localparam int TW         = $clog2(RESULT_WAIT);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PIXELS - 1);
   localparam logic [23:0]      BBRESET_CMD = 24'(BBRESET);
   localparam logic [TW-1:0]    WAIT_LOAD   = TW'(RESULT_WAIT - 1);

   loader_state_t    state, state_next;
   logic [IDX_W-1:0] idx;
   logic             beat;
   logic             last_beat;
   logic             timer_done;

   assign pix_ready = (state == LOAD);
   assign busy      = (state != IDLE);
   assign rd_en     = 1'b0;
   assign beat      = pix_valid & pix_ready;
   assign last_beat = beat && (idx == LAST_IDX);

   bbox_wait_timer #(.WIDTH(TW)) u_wait_timer (
      .CLOCK_50   (CLOCK_50),
      .reset_n    (reset_n),
      .load       (state == RELEASE),
      .en         (state == WAIT),
      .load_value (WAIT_LOAD),
      .done       (timer_done)
   );

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (frame_start) state_next = LOAD;
         LOAD:    if (last_beat) state_next = KICK;
         KICK:    state_next = RELEASE;
         RELEASE: state_next = WAIT;
         WAIT:    if (timer_done) state_next = CAPTURE;
         CAPTURE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered, so each state's bus action appears one cycle after it.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         wr_en           <= 1'b0;
         hex_value_index <= '0;
         idx             <= '0;
         frame_err       <= 1'b0;
         result          <= '0;
         result_valid    <= 1'b0;
      end else begin
         wr_en        <= 1'b0;
         result_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_start) begin
                  idx       <= '0;
                  frame_err <= 1'b0;
               end
            end
            LOAD: begin
               if (beat) begin
                  wr_en                               <= 1'b1;
                  hex_value_index[DATA_MSB:DATA_LSB]  <= pix_data;
                  hex_value_index[IDX_MSB:0]          <= 24'(idx);
                  idx                                 <= idx + 1'b1;
                  if (pix_last != (idx == LAST_IDX)) begin
                     frame_err <= 1'b1;
                  end
               end
            end
            KICK:    hex_value_index <= {8'h00, BBRESET_CMD};
            RELEASE: hex_value_index <= '0;
            WAIT: begin
               if (timer_done) begin
                  result       <= coordinates;
                  result_valid <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef BBOX_CHECKSUM_EN
   logic [15:0] sum;

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         sum <= '0;
      end else if (state == IDLE && frame_start) begin
         sum <= '0;
      end else if (beat) begin
         sum <= sum + 16'(pix_data);
      end
   end

   assign checksum = sum;
`else
   assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_bbox_image_loader.sv
// tb/tb_bbox_image_loader.sv - scoreboard bench for bbox_image_loader on a 4x4 image
module tb_bbox_image_loader;

   localparam int          N         = 16;
   localparam int          RW        = 8;
   localparam logic [31:0] KICK_WORD = 32'h0001869F;

   logic        CLOCK_50 = 1'b0;
   logic        reset_n;
   logic        frame_start;
   logic        pix_valid;
   logic [7:0]  pix_data;
   logic        pix_last;
   logic        pix_ready;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] hex_value_index;
   logic [31:0] coordinates;
   logic [31:0] result;
   logic        result_valid;
   logic        busy;
   logic        frame_err;
   logic [15:0] checksum;

   bbox_image_loader #(
      .IMG_W       (4),
      .IMG_H       (4),
      .BBRESET     (99999),
      .RESULT_WAIT (RW)
   ) dut (
      .CLOCK_50        (CLOCK_50),
      .reset_n         (reset_n),
      .frame_start     (frame_start),
      .pix_valid       (pix_valid),
      .pix_data        (pix_data),
      .pix_last        (pix_last),
      .pix_ready       (pix_ready),
      .wr_en           (wr_en),
      .rd_en           (rd_en),
      .hex_value_index (hex_value_index),
      .coordinates     (coordinates),
      .result          (result),
      .result_valid    (result_valid),
      .busy            (busy),
      .frame_err       (frame_err),
      .checksum        (checksum)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   typedef struct {
      logic [31:0] res;
      logic        err;
      logic [15:0] sum;
   } frame_exp_t;

   int          checks  = 0;
   int          errors  = 0;
   int          cyc     = 0;
   int          kicks   = 0;
   int          results = 0;
   int          kick_cyc = 0;
   bit          kick_prev = 0;
   bit          rv_prev   = 0;
   logic [31:0] exp_wr[$];
   frame_exp_t  exp_frame[$];
   logic [7:0]  pix[N];

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: consumes expectations whenever the DUT presents a write, a restart or a result.
   always @(negedge CLOCK_50) begin
      frame_exp_t fe;
      check("rd_en_low", rd_en, 0);
      if (wr_en) begin
         if (exp_wr.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=%h required=none", hex_value_index);
         end else begin
            check("write_word", hex_value_index, exp_wr.pop_front());
         end
      end
      if (kick_prev) check("release_word", hex_value_index, 32'h0);
      if (!wr_en && hex_value_index == KICK_WORD && !kick_prev) begin
         kicks++;
         kick_cyc = cyc;
         kick_prev = 1;
         check("writes_done_at_kick", exp_wr.size(), 0);
      end else begin
         kick_prev = 0;
      end
      if (rv_prev) begin
         check("result_valid_one_cycle", result_valid, 0);
         check("idle_after_result", busy, 0);
      end
      rv_prev = result_valid;
      if (result_valid) begin
         results++;
         if (exp_frame.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%h required=none", result);
         end else begin
            fe = exp_frame.pop_front();
            check("result", result, fe.res);
            check("frame_err", frame_err, fe.err);
            check("checksum", checksum, fe.sum);
            check("result_latency", cyc - kick_cyc, RW + 1);
         end
      end
   end

   // Reference: one write per pixel in order, restart then result; error iff last flag misplaced.
   task automatic run_frame(input int mode, input int last_pos, input int n_send,
                            input logic [31:0] coords, input bit complete, input bit poke);
      int          b;
      int          guard;
      int          r0;
      logic [15:0] sum;
      frame_exp_t  fe;
      coordinates = coords;
      sum = 16'h0;
      for (int i = 0; i < n_send; i++) begin
         exp_wr.push_back({pix[i], 24'(i)});
         sum += 16'(pix[i]);
      end
`ifndef BBOX_CHECKSUM_EN
      sum = 16'h0;
`endif
      fe.res = coords;
      fe.err = (last_pos != N - 1);
      fe.sum = sum;
      if (complete) exp_frame.push_back(fe);
      r0 = results;
      @(negedge CLOCK_50) frame_start = 1;
      @(negedge CLOCK_50) frame_start = 0;
      b = 0;
      guard = 0;
      while (b < n_send && guard < 300) begin
         case (mode)
            0:       pix_valid = 1;
            1:       pix_valid = (guard % 2 == 0);
            default: pix_valid = 1'($urandom_range(0, 1));
         endcase
         pix_data = pix_valid ? pix[b] : 8'($urandom);
         pix_last = pix_valid && (b == last_pos);
         if (pix_valid && pix_ready) b++;
         guard++;
         @(negedge CLOCK_50);
      end
      pix_valid = 0;
      pix_last  = 0;
      if (b < n_send) begin
         checks++;
         errors++;
         $display("FAIL beats_accepted actual=%0d required=%0d", b, n_send);
      end
      if (!complete) return;
      if (poke) begin
         repeat (3) @(negedge CLOCK_50);
         frame_start = 1;
         @(negedge CLOCK_50) frame_start = 0;
         check("busy_in_wait", busy, 1);
         check("no_ready_in_wait", pix_ready, 0);
      end
      guard = 0;
      while (results == r0 && guard < 100) begin
         @(posedge CLOCK_50);
         guard++;
      end
      if (results == r0) begin
         checks++;
         errors++;
         $display("FAIL result_timeout actual=none required=pulse");
      end
      repeat (2) @(negedge CLOCK_50);
   endtask

   initial begin
      #(100000 * 20);
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1);
   end

   initial begin
      int k0;
      reset_n     = 0;
      frame_start = 0;
      pix_valid   = 1;
      pix_data    = 8'hA5;
      pix_last    = 0;
      coordinates = 32'h0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_pix_ready", pix_ready, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_hex", hex_value_index, 0);
      check("rst_result_valid", result_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_result", result, 0);
      check("rst_checksum", checksum, 0);
      pix_valid = 0;
      reset_n   = 1;
      @(negedge CLOCK_50);

      for (int i = 0; i < N; i++) pix[i] = 8'(i + 8'h10);
      run_frame(0, N - 1, N, 32'h053A0741, 1, 0);
      run_frame(1, N - 1, N, 32'h053A0741, 1, 0);

      for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
      run_frame(2, 3, N, $urandom, 1, 1);

      for (int i = 0; i < N; i++) pix[i] = 8'hFF;
      run_frame(0, N - 1, N, 32'h01020304, 1, 0);

      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
         run_frame(2, (f == 2) ? N : N - 1, N, $urandom, 1, 0);
      end

      for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
      k0 = kicks;
      run_frame(0, N - 1, 8, 32'h0, 0, 0);
      reset_n = 0;
      @(negedge CLOCK_50);
      check("midreset_busy", busy, 0);
      check("midreset_wr_en", wr_en, 0);
      reset_n = 1;
      repeat (20) @(negedge CLOCK_50);
      check("midreset_no_kick", kicks, k0);
      check("midreset_writes_left", exp_wr.size(), 0);

      for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
      run_frame(2, N - 1, N, 32'hDEADBEEF, 1, 0);

      check("final_writes_left", exp_wr.size(), 0);
      check("final_results_left", exp_frame.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bbox_image_loader.md
Name: bbox_image_loader

Overview:
Write-side initiator for the bounding-box engine's packed load interface. Accepts a byte-wide pixel stream over a valid/ready handshake and emits one RAM write per pixel as wr_en plus hex_value_index ({pixel[7:0], index[23:0]}). After the last pixel it issues the restart command (index field = BBRESET) and waits a fixed number of cycles for processing. It then samples the engine's packed coordinates and presents them as a one-cycle result pulse.

Parameters:
IMG_W, 100, image width in pixels.
IMG_H, 100, image height in pixels; NUM_PIXELS = IMG_W*IMG_H (localparam), must be ≤ 30000.
BBRESET, 99999, index value that restarts the engine.
RESULT_WAIT, 65536, cycles from the restart command to coordinate capture; minimum 2.

Ports:
CLOCK_50  in  1  clock
reset_n  in  1  synchronous, active-low reset
frame_start  in  1  one-cycle pulse that begins a frame; ignored unless idle
pix_valid  in  1  pixel byte valid
pix_data  in  8  pixel byte, row-major
pix_last  in  1  asserted with the final pixel of the frame
pix_ready  out  1  loader accepts a pixel this cycle
wr_en  out  1  write strobe to the engine
rd_en  out  1  tied 0
hex_value_index  out  32  [31:24] pixel data, [23:0] RAM index or command
coordinates  in  32  engine result: xMin[31:24], xMax[23:16], yMin[15:8], yMax[7:0]
result  out  32  captured coordinates
result_valid  out  1  one-cycle pulse; result is valid on that cycle and held afterwards
busy  out  1  high in every state except IDLE
frame_err  out  1  sticky pix_last mismatch flag
checksum  out  16  see Optional Feature

Behaviour:
- Reset: state=IDLE. pix_ready, wr_en, rd_en, result_valid, busy and frame_err are 0. hex_value_index=0, result=0, idx=0, wait counter=0, checksum=0.
- FSM states: IDLE, LOAD, KICK, RELEASE, WAIT, CAPTURE.
- IDLE:
  - pix_ready=0.
  - On frame_start: go to LOAD, idx←0, frame_err←0, checksum←0.
- LOAD:
  - pix_ready=1 combinationally from state.
  - Beat accepted when pix_valid & pix_ready.
  - On an accepted beat, registered on the next edge: wr_en←1, hex_value_index←{pix_data, idx zero-extended to 24 bits}, idx←idx+1.
  - On a cycle with no beat: wr_en←0 and hex_value_index holds its value.
  - Write latency is 1 cycle from acceptance. Throughput is 1 pixel/cycle, so back-to-back beats produce back-to-back writes.
- pix_last check:
  - pix_last on beat idx<NUM_PIXELS-1: frame_err←1 and the frame continues.
  - pix_last low on beat NUM_PIXELS-1: frame_err←1.
  - The loader always ends the frame after exactly NUM_PIXELS beats.
- KICK:
  - Entered after beat NUM_PIXELS-1 is accepted.
  - One cycle with wr_en←0, hex_value_index←{8'h00, BBRESET[23:0]}.
- RELEASE:
  - One cycle with hex_value_index←0, wr_en←0. This lets the engine leave its init state.
  - Wait counter←0.
- WAIT:
  - Counter increments each cycle.
  - When counter==RESULT_WAIT-1, go to CAPTURE.
- CAPTURE:
  - result←coordinates, result_valid←1 for one cycle, then go to IDLE.
- frame_start while busy is ignored and does not restart the frame.
- Simultaneous frame_start with reset: reset wins.
- Reset mid-frame: immediate return to IDLE. Pixels already written remain in the engine's RAM, and no restart command is issued.
- idx width is clog2(NUM_PIXELS). idx never wraps because the frame ends at NUM_PIXELS-1.
- wr_en is never asserted during KICK, RELEASE, WAIT or CAPTURE.

Optional Feature:
- Macro: BBOX_CHECKSUM_EN.
- Defined: checksum accumulates the mod-2^16 sum of all accepted pix_data in the frame. It is cleared on frame_start and stable from KICK onward.
- Undefined: checksum is tied to 16'h0000 and no accumulator logic is generated.

Decomposition:
- Package bbox_pkg holds:
  - state enum loader_state_t;
  - BBRESET default;
  - field-position constants for hex_value_index (DATA_MSB=31, DATA_LSB=24, IDX_MSB=23);
  - coordinate byte offsets.
- One natural sub-module: bbox_wait_timer, a loadable down-counter with a done pulse, used for RESULT_WAIT.

Test Plan:
- Reset held 3 cycles with pix_valid=1 → pix_ready=0, wr_en=0, hex_value_index=0, result_valid=0.
- IMG_W=IMG_H=4, frame_start then 16 back-to-back beats with data=idx+8'h10 and pix_last on beat 15:
  - wr_en for 16 consecutive cycles, first hex_value_index=32'h10000000, last 32'h1F00000F;
  - next cycles 32'h0001869F then 32'h00000000.
- Same frame with pix_valid toggling 1/0 → writes only on accepted beats, indices 0..15 contiguous, frame_err=0.
- RESULT_WAIT=8 with coordinates held at 32'h05_3A_07_41 → result_valid pulses once, exactly 9 cycles after the KICK cycle, with result=32'h053A0741, then busy=0.
- pix_last on beat 3 of 16 → frame_err=1, all 16 writes still issued; a frame_start pulse during WAIT is ignored (busy stays 1, no new writes).
- BBOX_CHECKSUM_EN defined, 16 beats of 8'hFF → checksum=16'h0FF0. Undefined → checksum=0.
- reset_n low after beat 7 → IDLE next edge, no KICK command observed.
